pipe_stage_skid: RTL

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

---
 rtl/pipe_stage_skid.sv | 110 +++++++++++
 1 files changed

// File: rtl/pipe_stage_skid.sv
// Two-entry elastic pipeline stage: a main register driving the outputs plus a
// skid register, so in_ready depends only on registered state.
module pipe_stage_skid #(
    parameter int DATA_W = 32,
    parameter int DEST_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_regwrite,
    input  logic [DEST_W-1:0] in_dest,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_regwrite,
    output logic [DEST_W-1:0] out_dest,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t              state_reg;
    logic                m_regwrite_reg;
    logic [DEST_W-1:0]   m_dest_reg;
    logic [DATA_W-1:0]   m_data_reg;
    logic                s_regwrite_reg;
    logic [DEST_W-1:0]   s_dest_reg;
    logic [DATA_W-1:0]   s_data_reg;
    logic [CNT_W-1:0]    stall_cnt_reg;

    logic accept;
    logic rel;

    // Handshake flags come purely from the state register.
    assign in_ready  = (state_reg != FULL);
    assign out_valid = (state_reg != EMPTY);
    assign accept    = in_valid & in_ready;
    assign rel       = out_valid & out_ready;

    assign occupancy    = state_reg;
    assign out_regwrite = m_regwrite_reg & out_valid;
    assign out_dest     = m_dest_reg;
    assign out_data     = m_data_reg;
    assign stall_cnt    = stall_cnt_reg;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_reg      <= EMPTY;
            m_regwrite_reg <= 1'b0;
            m_dest_reg     <= '0;
            m_data_reg     <= '0;
            s_regwrite_reg <= 1'b0;
            s_dest_reg     <= '0;
            s_data_reg     <= '0;
            stall_cnt_reg  <= '0;
        end else begin
            // Stall counting is independent of flush and saturates.
            if (out_valid && !out_ready && (stall_cnt_reg != {CNT_W{1'b1}}))
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);

            if (flush) begin
                state_reg <= EMPTY;
            end else begin
                case (state_reg)
                    EMPTY: begin
                        if (accept) begin
                            m_regwrite_reg <= in_regwrite;
                            m_dest_reg     <= in_dest;
                            m_data_reg     <= in_data;
                            state_reg      <= ONE;
                        end
                    end
                    ONE: begin
                        if (accept && rel) begin
                            m_regwrite_reg <= in_regwrite;
                            m_dest_reg     <= in_dest;
                            m_data_reg     <= in_data;
                        end else if (accept) begin
                            s_regwrite_reg <= in_regwrite;
                            s_dest_reg     <= in_dest;
                            s_data_reg     <= in_data;
                            state_reg      <= FULL;
                        end else if (rel) begin
                            state_reg <= EMPTY;
                        end
                    end
                    FULL: begin
                        if (rel) begin
                            m_regwrite_reg <= s_regwrite_reg;
                            m_dest_reg     <= s_dest_reg;
                            m_data_reg     <= s_data_reg;
                            state_reg      <= ONE;
                        end
                    end
                    default: state_reg <= EMPTY;
                endcase
            end
        end
    end

endmodule
